// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: sole owner of the single-port text VRAM; scan-out wins, CPU fills free slots.
// Ports: pclk/reset_n; scan_req/x/y -> scan_ascii/vld; cpu_req/we/addr/wdata -> cpu_ready/rvalid/rdata;
//        busy; vram_en/we/addr/wdata, vram_rdata (1-cycle sync read).
// Optional: define VRAM_CLEAR_EN to blank the whole VRAM with 8'h20 after every reset.
`timescale 1ns/1ps
module vga_vram_arbiter #(
   parameter int COLS   = 70,
   parameter int ROWS   = 30,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              pclk,
   input  logic              reset_n,
   input  logic              scan_req,
   input  logic [6:0]        scan_x,
   input  logic [4:0]        scan_y,
   output logic [DATA_W-1:0] scan_ascii,
   output logic              scan_vld,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              busy,
   output logic              vram_en,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata
);

   localparam int                NCELL = COLS * ROWS;
   localparam logic [ADDR_W-1:0] NC_A  = ADDR_W'(NCELL);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NCELL - 1);
   localparam logic [6:0]        COL_X = 7'(COLS);
   localparam logic [4:0]        ROW_Y = 5'(ROWS);
   localparam logic [DATA_W-1:0] BLANK = DATA_W'(8'h20);

   logic              scan_pend;
   logic [6:0]        pend_x;
   logic [4:0]        pend_y;
   logic              rd_vld;
   logic              rd_cpu;
   logic              rd_zero;
   logic              hold;
   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;

   logic              scan_go;
   logic [6:0]        sx;
   logic [4:0]        sy;
   logic              scan_in;
   logic [ADDR_W-1:0] scan_addr;
   logic              scan_ram;
   logic              scan_blank;
   logic              cpu_fire;
   logic              cpu_in;

`ifdef VRAM_CLEAR_EN
   // START gives one quiet cycle after reset so busy/strobes read 0 in reset
   typedef enum logic [1:0] {ST_START, ST_CLEAR, ST_IDLE} state_t;
   state_t st;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         st       <= ST_START;
         clr_addr <= '0;
      end else begin
         case (st)
            ST_START: st <= ST_CLEAR;
            ST_CLEAR: begin
               if (clr_addr == LAST) st <= ST_IDLE;
               else clr_addr <= clr_addr + 1'b1;
            end
            default:  st <= ST_IDLE;
         endcase
      end
   end

   assign busy   = (st == ST_CLEAR);
   assign clr_en = busy;
   assign hold   = (st != ST_IDLE);
`else
   assign busy     = 1'b0;
   assign clr_en   = 1'b0;
   assign hold     = 1'b0;
   assign clr_addr = '0;
`endif

   // a fresh request overrides any latched coords (newest wins)
   assign scan_go    = scan_req | scan_pend;
   assign sx         = scan_req ? scan_x : pend_x;
   assign sy         = scan_req ? scan_y : pend_y;
   assign scan_in    = (sx < COL_X) && (sy < ROW_Y);
   assign scan_addr  = ADDR_W'(sy) * ADDR_W'(COLS) + ADDR_W'(sx);
   assign scan_ram   = scan_go & scan_in & ~hold;
   // off-screen cells and fetches during clear are answered without RAM
   assign scan_blank = scan_go & (~scan_in | hold);

   assign cpu_ready = ~scan_req & ~scan_pend & ~busy & ~hold;
   assign cpu_fire  = cpu_req & cpu_ready;
   assign cpu_in    = (cpu_addr < NC_A);

   always_comb begin
      vram_en    = 1'b0;
      vram_we    = 1'b0;
      vram_addr  = '0;
      vram_wdata = '0;
      if (clr_en) begin
         vram_en    = 1'b1;
         vram_we    = 1'b1;
         vram_addr  = clr_addr;
         vram_wdata = BLANK;
      end else if (scan_ram) begin
         vram_en   = 1'b1;
         vram_addr = scan_addr;
      end else if (cpu_fire && cpu_in) begin
         vram_en    = 1'b1;
         vram_we    = cpu_we;
         vram_addr  = cpu_addr;
         vram_wdata = cpu_wdata;
      end
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         scan_pend  <= 1'b0;
         pend_x     <= '0;
         pend_y     <= '0;
         rd_vld     <= 1'b0;
         rd_cpu     <= 1'b0;
         rd_zero    <= 1'b0;
         scan_ascii <= BLANK;
         scan_vld   <= 1'b0;
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
      end else begin
         // scan owns every slot, so a pending fetch only survives an unserved cycle
         scan_pend <= scan_go & ~(scan_ram | scan_blank);
         if (scan_req) begin
            pend_x <= scan_x;
            pend_y <= scan_y;
         end
         // tag the read in flight; scan and CPU never issue in the same cycle
         rd_vld  <= scan_ram | (cpu_fire & ~cpu_we);
         rd_cpu  <= ~scan_ram;
         rd_zero <= ~cpu_in;

         scan_vld   <= 1'b0;
         cpu_rvalid <= 1'b0;
         if (rd_vld && !rd_cpu) begin
            scan_ascii <= vram_rdata;
            scan_vld   <= 1'b1;
         end else if (scan_blank) begin
            scan_ascii <= BLANK;
            scan_vld   <= 1'b1;
         end
         if (rd_vld && rd_cpu) begin
            cpu_rdata  <= rd_zero ? '0 : vram_rdata;
            cpu_rvalid <= 1'b1;
         end
      end
   end

endmodule
